// File: rtl/ivector_pkg.sv
// ivector_pkg: shared widths, FSM state and
// report bundle for the item vector collector.
package ivector_pkg;

  localparam int WIDTH     = 32;
  localparam int DEF_DEPTH = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] meth;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] sum;
  } report_t;

endpackage

// File: rtl/ivector_collect.sv
// ivector_collect: per-channel count/sum with batch and flush reports.
// Optional drop_count output under IVECTOR_COLLECT_DROPCNT_EN.
module ivector_collect
  import ivector_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int BATCH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_heard__ENA,
  input  logic [WIDTH-1:0] in_heard_meth,
  input  logic [WIDTH-1:0] in_heard_v,
  output logic             in_heard__RDY,
  input  logic             flush__ENA,
  output logic             flush__RDY,
  output logic             out_report__ENA,
  output logic [WIDTH-1:0] out_report_meth,
  output logic [WIDTH-1:0] out_report_count,
  output logic [WIDTH-1:0] out_report_sum,
  input  logic             out_report__RDY
`ifdef IVECTOR_COLLECT_DROPCNT_EN
  ,
  output logic [WIDTH-1:0] drop_count
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] BATCH_W = WIDTH'(BATCH);

  state_t           state;
  state_t           state_nx;
  logic [IW-1:0]    ptr;
  logic             valid;
  report_t          rpt;
  logic [WIDTH-1:0] cnt_q [DEPTH];
  logic [WIDTH-1:0] sum_q [DEPTH];

  logic             heard_fire;
  logic             flush_fire;
  logic             in_range;
  logic             scan_step;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] add_cnt;
  logic [WIDTH-1:0] add_sum;

  assign heard_fire = in_heard__ENA && in_heard__RDY;
  assign flush_fire = flush__ENA && flush__RDY;
  assign in_range   = in_heard_meth < WIDTH'(DEPTH);
  assign idx        = in_heard_meth[IW-1:0];
  assign add_cnt    = cnt_q[idx] + WIDTH'(1);
  assign add_sum    = sum_q[idx] + in_heard_v;
  assign scan_step  = (state == SCAN) && !valid;

  // state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  // next state: flush starts a scan, last channel ends it
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (flush_fire) state_nx = SCAN;
      SCAN: if (scan_step && ptr == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ready only when idle with an empty report slot
  always_comb begin
    in_heard__RDY = (state == IDLE) && !valid;
    flush__RDY    = (state == IDLE) && !valid;
  end

  // channel accumulators, scan pointer and report slot
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      rpt   <= '0;
      ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      if (valid && out_report__RDY) valid <= 1'b0;
      if (flush_fire) ptr <= '0;
      if (heard_fire && in_range) begin
        if (add_cnt == BATCH_W) begin
          valid      <= 1'b1;
          rpt        <= '{in_heard_meth, BATCH_W, add_sum};
          cnt_q[idx] <= '0;
          sum_q[idx] <= '0;
        end else begin
          cnt_q[idx] <= add_cnt;
          sum_q[idx] <= add_sum;
        end
      end
      if (scan_step) begin
        if (cnt_q[ptr] != '0) begin
          valid      <= 1'b1;
          rpt        <= '{WIDTH'(ptr), cnt_q[ptr], sum_q[ptr]};
          cnt_q[ptr] <= '0;
          sum_q[ptr] <= '0;
        end
        if (ptr != LAST) ptr <= ptr + IW'(1);
      end
    end
  end

`ifdef IVECTOR_COLLECT_DROPCNT_EN
  // saturating count of out-of-range items
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      drop_count <= '0;
    end else if (heard_fire && !in_range && drop_count != '1) begin
      drop_count <= drop_count + WIDTH'(1);
    end
  end
`endif

  assign out_report__ENA   = valid;
  assign out_report_meth   = rpt.meth;
  assign out_report_count  = rpt.count;
  assign out_report_sum    = rpt.sum;

endmodule

// File: doc/ivector_collect.md
IVECTOR_COLLECT -- requirements
Module: ivector_collect

Interface
REQ-001 Parameter DEPTH, default 10: number of channels, indexed by meth.
REQ-002 Parameter BATCH, default 4: accepted items per channel that trigger a report.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-low reset, named CLK and nRST as elsewhere in the codebase.
REQ-004 CLK  in  1  clock.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 in$heard__ENA  in  1  upstream item valid; only legal while in$heard__RDY=1.
REQ-007 in$heard$meth  in  32  channel index.
REQ-008 in$heard$v  in  32  item value.
REQ-009 in$heard__RDY  out  1  block can accept an item.
REQ-010 flush__ENA  in  1  request to drain all non-empty channels; only legal while flush__RDY=1.
REQ-011 flush__RDY  out  1  flush can be accepted.
REQ-012 out$report__ENA  out  1  report valid.
REQ-013 out$report$meth  out  32  channel of report.
REQ-014 out$report$count  out  32  items accumulated.
REQ-015 out$report$sum  out  32  sum of item values.
REQ-016 out$report__RDY  in  1  downstream accepts report.

Function
REQ-017 Per channel: count and sum registers, 32 bits each; sum wraps modulo 2^32.
REQ-018 One-entry report register (valid, meth, count, sum) drives out$report*; out$report__ENA = valid.
REQ-019 Transfer on out$report__ENA && out$report__RDY; valid clears next cycle; data stays stable while ENA=1 and RDY=0.
REQ-020 FSM states IDLE, SCAN; in$heard__RDY = (state==IDLE) && !valid; flush__RDY = in$heard__RDY. No RDY depends combinationally on any input.
REQ-021 Accepted item with meth<DEPTH: count+=1, sum+=v; if new count==BATCH, the report register loads {meth, BATCH, new sum} at the same edge, and the channel clears to 0/0. The report is visible one cycle after acceptance.
REQ-022 Accepted item with meth>=DEPTH: accepted and dropped; no channel state change.
REQ-023 Accepted flush: IDLE->SCAN with ptr=0.
REQ-024 SCAN, each cycle with valid=0: if count[ptr]!=0, load report {ptr, count, sum} and clear the channel; if ptr==DEPTH-1, go to IDLE, else ptr+=1. With valid=1, the FSM holds.
REQ-025 Flush reports are emitted in ascending channel order. Empty channels produce no report. A flush with all channels empty returns to IDLE after DEPTH cycles.
REQ-026 Reports take exactly one handshake each; nothing is dropped or duplicated.

Reset
REQ-027 nRST low SHALL immediately clear all counts, sums, valid, ptr, and the drop counter, and force state IDLE, including mid-SCAN or while a report is pending.
REQ-028 Reset output values: out$report__ENA=0; meth/count/sum=0; in$heard__RDY=1; flush__RDY=1.

Configuration
REQ-029 Macro IVECTOR_COLLECT_DROPCNT_EN defined: add output drop_count (32-bit, out). It increments on each item dropped per REQ-022, saturates at 32'hFFFFFFFF, and resets to 0.
REQ-030 Macro undefined: no drop_count port and no counter logic; behaviour is otherwise identical.

Structure
REQ-031 Shared package ivector_pkg holds: WIDTH=32, default DEPTH=10, the FSM state enum, and the packed report struct {meth, count, sum}.
REQ-032 No sub-module; the channel arrays and FSM live in ivector_collect.

Verification
REQ-033 Items meth=3 with v=1,2,3,4 back-to-back, RDY=1 -> one cycle after the 4th item: report (3,4,10); channel 3 count=0.
REQ-034 Report pending with out$report__RDY=0 for 5 cycles -> ENA and data stable, in$heard__RDY=0 throughout; input resumes the cycle after the handshake.
REQ-035 Items (1,5), (7,9), (7,9), then flush -> reports (1,1,5) then (7,2,18); in$heard__RDY=0 until the FSM returns to IDLE.
REQ-036 Item meth=10 v=100 -> accepted, no report, all channels unchanged; with the macro defined, drop_count=1.
REQ-037 meth=0 with v=32'hFFFFFFFF four times -> report (0,4,32'hFFFFFFFC).
REQ-038 nRST asserted mid-SCAN with a report pending -> ENA=0 immediately; after release, flush yields no reports.
